monitored_ram: RTL and testbench
================================

Name: monitored_ram

Overview:
- Small synchronous single-port data RAM used as the backing store behind the 4-entry fully associative cache.
- Single clock, synchronous active-high clear, chip enable, read/write select and registered read data.
- Exposes the first eight words as continuous monitor outputs so the surrounding design and benches can observe memory contents directly.

Parameters:
- D_WIDTH, 8, data word width in bits.
- A_WIDTH, 8, address bus width in bits.
- DEPTH, 8, number of stored words. Must be a power of two and at least 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high clear; highest priority.
- enab  input  1  chip enable; 1 = perform the access selected by rw, 0 = idle.
- rw  input  1  0 = read, 1 = write.
- addr  input  A_WIDTH  target word address.
- data_in  input  D_WIDTH  write data.
- mem0 … mem7  output  D_WIDTH each  continuous view of words 0 through 7.
- data_out  output  D_WIDTH  registered read data.

Behaviour:
- Storage: DEPTH words of D_WIDTH bits. Word index = addr modulo DEPTH (low log2(DEPTH) bits; upper address bits ignored, so addresses wrap, e.g. address 8 aliases word 0).
- Per rising clk edge, priority order:
  - clr=1: all words and data_out cleared to 0. enab, rw, addr and data_in are ignored.
  - clr=0, enab=0: no change to memory or data_out (data_out holds its last value).
  - clr=0, enab=1, rw=0 (read): data_out <= word[addr]. Memory unchanged.
  - clr=0, enab=1, rw=1 (write): word[addr] <= data_in. data_out holds its last value; no write-through to data_out.
- Read latency: one clock. Address presented before edge N gives data_out valid after edge N, held until the next read or clear.
- Read of a word in the same cycle as a clear returns 0 afterwards (clear wins).
- Back-to-back write then read of the same address: the read on the following edge returns the newly written value.
- mem0…mem7 are combinational views of the storage. They update immediately after the edge that writes or clears them; no extra latency.
- Power-up: memory and data_out undefined until the first clr=1 edge; the system must assert clr at start-up.
- No handshake or busy signal; every enabled access completes in one cycle.

Decomposition:
- Shared package: D_WIDTH and A_WIDTH defaults (8/8) shared with the cache; RAM_DEPTH=8 constant.
- No sub-module. Single flat module with one storage array, one clocked process and continuous monitor assignments.

Test Plan:
- Clear: preload words with nonzero data, hold clr=1 for one edge with enab=1, rw=1, addr=3, data_in=0xAA -> all mem0…mem7=0x00, data_out=0x00, word 3 not written.
- Write/read: clr=0, enab=1, rw=1, addr=5, data_in=0x3C; next cycle rw=0, addr=5 -> mem5=0x3C right after the write edge, data_out=0x3C after the read edge.
- Enable gating: enab=0, rw=1, addr=2, data_in=0xFF -> mem2 unchanged (0x00), data_out unchanged. Then enab=0, rw=0 -> data_out still holds its prior value.
- Address wrap: write 0x5A to addr=10 -> mem2=0x5A; read addr=2 -> data_out=0x5A.
- Write holds output: read addr=5 (data_out=0x3C), then write 0x77 to addr=1 -> data_out stays 0x3C, mem1=0x77.
- Full sweep: write value 0x10+i to addresses 0…7, then read each back -> mem_i=0x10+i and each read returns 0x10+i one cycle after its address is presented.

Source files
------------

// File: rtl/monitored_ram_pkg.sv
// Shared sizing constants for the backing RAM and the cache in front of it.
package monitored_ram_pkg;

  localparam int unsigned D_WIDTH   = 8;
  localparam int unsigned A_WIDTH   = 8;
  localparam int unsigned RAM_DEPTH = 8;

endpackage

// File: rtl/monitored_ram.sv
// Single-port synchronous RAM with registered read data and a live view of words 0..7.
module monitored_ram
  import monitored_ram_pkg::*;
#(
  parameter int unsigned D_WIDTH = monitored_ram_pkg::D_WIDTH,
  parameter int unsigned A_WIDTH = monitored_ram_pkg::A_WIDTH,
  parameter int unsigned DEPTH   = RAM_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_clr,
  input  logic               i_enab,
  input  logic               i_rw,
  input  logic [A_WIDTH-1:0] i_addr,
  input  logic [D_WIDTH-1:0] i_data_in,
  output logic [D_WIDTH-1:0] o_mem0,
  output logic [D_WIDTH-1:0] o_mem1,
  output logic [D_WIDTH-1:0] o_mem2,
  output logic [D_WIDTH-1:0] o_mem3,
  output logic [D_WIDTH-1:0] o_mem4,
  output logic [D_WIDTH-1:0] o_mem5,
  output logic [D_WIDTH-1:0] o_mem6,
  output logic [D_WIDTH-1:0] o_mem7,
  output logic [D_WIDTH-1:0] o_data_out
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic [D_WIDTH-1:0] r_data_out;
  logic [IDX_W-1:0]   w_idx;

  // Upper address bits are ignored, so addresses alias modulo DEPTH.
  assign w_idx = i_addr[IDX_W-1:0];

  if (A_WIDTH > IDX_W) begin : g_unused_addr
    logic w_unused_addr;
    assign w_unused_addr = ^i_addr[A_WIDTH-1:IDX_W];
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_data_out <= '0;
    end else if (i_enab) begin
      if (i_rw) begin
        r_mem[w_idx] <= i_data_in;
      end else begin
        r_data_out <= r_mem[w_idx];
      end
    end
  end

  assign o_mem0     = r_mem[0];
  assign o_mem1     = r_mem[1];
  assign o_mem2     = r_mem[2];
  assign o_mem3     = r_mem[3];
  assign o_mem4     = r_mem[4];
  assign o_mem5     = r_mem[5];
  assign o_mem6     = r_mem[6];
  assign o_mem7     = r_mem[7];
  assign o_data_out = r_data_out;

endmodule

// File: tb/tb_monitored_ram.sv
// Directed and randomized checks of monitored_ram against a simple array model.
module tb_monitored_ram;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       enab = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] mem0, mem1, mem2, mem3, mem4, mem5, mem6, mem7;
  logic [7:0] data_out;
  logic [7:0] mon [8];

  int checks = 0;
  int errors = 0;

  // Reference model: eight words and the last read value.
  logic [7:0] m_mem [8];
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  assign mon[0] = mem0;
  assign mon[1] = mem1;
  assign mon[2] = mem2;
  assign mon[3] = mem3;
  assign mon[4] = mem4;
  assign mon[5] = mem5;
  assign mon[6] = mem6;
  assign mon[7] = mem7;

  monitored_ram dut (
    .i_clk      (clk),
    .i_clr      (clr),
    .i_enab     (enab),
    .i_rw       (rw),
    .i_addr     (addr),
    .i_data_in  (data_in),
    .o_mem0     (mem0),
    .o_mem1     (mem1),
    .o_mem2     (mem2),
    .o_mem3     (mem3),
    .o_mem4     (mem4),
    .o_mem5     (mem5),
    .o_mem6     (mem6),
    .o_mem7     (mem7),
    .o_data_out (data_out)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("model_mem%0d", i), mon[i], m_mem[i]);
    end
    check("model_dout", data_out, m_dout);
  endtask

  // Drive one cycle, apply the access rules to the model, then compare everything.
  task automatic step(input logic c, input logic e, input logic w,
                      input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    clr = c; enab = e; rw = w; addr = a; data_in = d;
    @(posedge clk);
    if (c) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      m_dout = 8'h00;
    end else if (e) begin
      if (w) m_mem[a % 8] = d;
      else   m_dout = m_mem[a % 8];
    end
    #1;
    check_model();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_dout = 8'h00;

    step(1'b1, 1'b0, 1'b0, 8'd0, 8'h00);
    check("reset_dout", data_out, 8'h00);

    // Clear beats a simultaneous write
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 8'(i), 8'(8'hC0 + i));
    step(1'b0, 1'b1, 1'b0, 8'd6, 8'h00);
    check("preload_read", data_out, 8'hC6);
    step(1'b1, 1'b1, 1'b1, 8'd3, 8'hAA);
    check("clr_mem3", mem3, 8'h00);
    check("clr_mem0", mem0, 8'h00);
    check("clr_dout", data_out, 8'h00);

    step(1'b0, 1'b1, 1'b1, 8'd5, 8'h3C);
    check("wr_mem5", mem5, 8'h3C);
    check("wr_no_through", data_out, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'd5, 8'h00);
    check("rd_5", data_out, 8'h3C);

    step(1'b0, 1'b0, 1'b1, 8'd2, 8'hFF);
    check("gate_mem2", mem2, 8'h00);
    check("gate_dout_w", data_out, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 8'd2, 8'h00);
    check("gate_dout_r", data_out, 8'h3C);

    step(1'b0, 1'b1, 1'b1, 8'd10, 8'h5A);
    check("wrap_mem2", mem2, 8'h5A);
    step(1'b0, 1'b1, 1'b0, 8'd2, 8'h00);
    check("wrap_rd", data_out, 8'h5A);

    step(1'b0, 1'b1, 1'b0, 8'd5, 8'h00);
    check("hold_rd5", data_out, 8'h3C);
    step(1'b0, 1'b1, 1'b1, 8'd1, 8'h77);
    check("hold_dout", data_out, 8'h3C);
    check("hold_mem1", mem1, 8'h77);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 8'(i), 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sweep_mem%0d", i), mon[i], 8'(8'h10 + i));
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i), 8'h00);
      check($sformatf("sweep_rd%0d", i), data_out, 8'(8'h10 + i));
    end

    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
